pll_phase_ctrl: RTL and testbench



---
 rtl/pll_phase_ctrl_pkg.sv | 34 +++
 rtl/pll_phase_ctrl_lock_qualifier.sv | 73 +++++++
 rtl/pll_phase_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and helpers for the PLL phase/reset sequencer.
//   state_e         sequencer states
//   SEL_*           PHASESEL1:0 codes for the EHXPLLL outputs
//   cnt_w / imax    counter sizing helpers
package pll_phase_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RESET,
      ST_WAIT_LOCK,
      ST_IDLE,
      ST_SETUP,
      ST_STEP_LO,
      ST_STEP_HI,
      ST_LOAD_LO,
      ST_LOAD_HI,
      ST_SETTLE,
      ST_DONE
   } state_e;

   localparam logic [1:0] SEL_CLKOS  = 2'd0;
   localparam logic [1:0] SEL_CLKOS2 = 2'd1;
   localparam logic [1:0] SEL_CLKOS3 = 2'd2;
   localparam logic [1:0] SEL_CLKOP  = 2'd3;

   // Width for a counter that runs 0 .. max_val-1.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_phase_ctrl_lock_qualifier.sv
// Lock qualifier for the PLL LOCK pin.
// Synchronises the asynchronous LOCK input, counts consecutive synced-high
// cycles and total cycles while the sequencer waits for lock, and derives the
// qualified-lock and lock-loss indications.
// Ports:
//   clk_i, rst_n_i   reference clock, synchronous active-low reset
//   pll_locked_i     raw PLL LOCK (asynchronous)
//   wait_lock_i      sequencer is in WAIT_LOCK
//   active_i         sequencer is in IDLE..DONE (lock already qualified)
//   lk_s_o           synchronised LOCK
//   qual_o           LOCK_STABLE consecutive high cycles reached this cycle
//   timeout_o        LOCK_TIMEOUT cycles spent waiting, reached this cycle
//   locked_o         qualified lock
//   lockloss_o       qualified lock lost this cycle
module lock_qualifier #(
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int CW           = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic pll_locked_i,
   input  logic wait_lock_i,
   input  logic active_i,
   output logic lk_s_o,
   output logic qual_o,
   output logic timeout_o,
   output logic locked_o,
   output logic lockloss_o
);

   localparam logic [CW-1:0] STABLE_TC  = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT - 1);

   logic          lk_meta_q, lk_s_q;
   logic [CW-1:0] stable_q, stable_d;
   logic [CW-1:0] to_q, to_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
         stable_q  <= '0;
         to_q      <= '0;
      end else begin
         lk_meta_q <= pll_locked_i;
         lk_s_q    <= lk_meta_q;
         stable_q  <= stable_d;
         to_q      <= to_d;
      end
   end

   assign qual_o    = wait_lock_i && lk_s_q && (stable_q == STABLE_TC);
   assign timeout_o = wait_lock_i && (to_q == TIMEOUT_TC);

   // Both counters only live while waiting; they drop to zero the moment the
   // wait ends so the next wait starts clean.
   always_comb begin
      stable_d = '0;
      to_d     = '0;
      if (wait_lock_i && !qual_o && !timeout_o) begin
         to_d = to_q + CW'(1);
         if (lk_s_q) begin
            stable_d = stable_q + CW'(1);
         end
      end
   end

   assign lk_s_o     = lk_s_q;
   assign locked_o   = active_i && lk_s_q;
   assign lockloss_o = active_i && !lk_s_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for the ECP5 EHXPLLL reset and dynamic-phase pins, clocked from
// the PLL reference clock. Resets the PLL, qualifies lock, recovers from lock
// loss and runs phase-step requests taken over a valid/ready handshake.
// Optional: define PLL_PHASE_CTRL_TRACK_EN to add phase_acc_o, one signed
// (STEPW+4)-bit saturating step accumulator per PHASESEL code.
// Ports:
//   clk_i, rst_n_i          reference clock, synchronous active-low reset
//   pll_locked_i            PLL LOCK (asynchronous)
//   pll_rst_o               PLL RST, active high
//   phasesel_o, phasedir_o  PHASESEL1:0 (00 CLKOS .. 11 CLKOP), PHASEDIR
//   phasestep_o             PHASESTEP, idle high, active-low pulses
//   phaseloadreg_o          PHASELOADREG, idle high, active-low pulse
//   req_valid_i/req_ready_o request handshake
//   req_sel_i/dir_i/steps_i request fields, stable while valid
//   done_o                  one-cycle pulse when a request completes
//   locked_o, lockloss_o    qualified lock, one-cycle lock-loss pulse
//   phase_acc_o             step accumulators (TRACK_EN builds only)
//
// state      | meaning
// RESET      | pll_rst high for RST_CYCLES
// WAIT_LOCK  | waiting for LOCK_STABLE synced-high cycles or timeout
// IDLE       | locked, ready for a request
// SETUP      | sel/dir driven, settle before the first step edge
// STEP_LO    | phasestep low
// STEP_HI    | phasestep high, one step retired at the end
// LOAD_LO    | phaseloadreg low
// LOAD_HI    | phaseloadreg high
// SETTLE     | wait for the new phase to settle
// DONE       | done pulse
module pll_phase_ctrl
   import pll_phase_ctrl_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_STABLE   = 1024,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STEP_CYCLES   = 4,
   parameter int SETTLE_CYCLES = 64,
   parameter int STEPW         = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             pll_locked_i,
   output logic             pll_rst_o,
   output logic [1:0]       phasesel_o,
   output logic             phasedir_o,
   output logic             phasestep_o,
   output logic             phaseloadreg_o,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_sel_i,
   input  logic             req_dir_i,
   input  logic [STEPW-1:0] req_steps_i,
   output logic             done_o,
   output logic             locked_o,
   output logic             lockloss_o
`ifdef PLL_PHASE_CTRL_TRACK_EN
   ,
   output logic [4*(STEPW+4)-1:0] phase_acc_o
`endif
);

   localparam int CNT_MAX = imax(imax(imax(RST_CYCLES, LOCK_STABLE),
                                      imax(LOCK_TIMEOUT, STEP_CYCLES)),
                                 SETTLE_CYCLES);
   localparam int CW = cnt_w(CNT_MAX);

   localparam logic [CW-1:0] TC_RST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TC_STEP   = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] TC_SETTLE = CW'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    tmr_q, tmr_d;
   logic [1:0]       sel_q, sel_d;
   logic             dir_q, dir_d;
   logic [STEPW-1:0] steps_q, steps_d;

   logic lk_s, qual, timeout, lockloss, active;

   assign active = (state_q != ST_RESET) && (state_q != ST_WAIT_LOCK);

   lock_qualifier #(
      .LOCK_STABLE  (LOCK_STABLE),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .CW           (CW)
   ) u_lock_qualifier (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .pll_locked_i (pll_locked_i),
      .wait_lock_i  (state_q == ST_WAIT_LOCK),
      .active_i     (active),
      .lk_s_o       (lk_s),
      .qual_o       (qual),
      .timeout_o    (timeout),
      .locked_o     (locked_o),
      .lockloss_o   (lockloss)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_RESET;
         tmr_q   <= '0;
         sel_q   <= SEL_CLKOS;
         dir_q   <= 1'b0;
         steps_q <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         sel_q   <= sel_d;
         dir_q   <= dir_d;
         steps_q <= steps_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      tmr_d          = tmr_q + CW'(1);
      sel_d          = sel_q;
      dir_d          = dir_q;
      steps_d        = steps_q;
      pll_rst_o      = 1'b0;
      phasestep_o    = 1'b1;
      phaseloadreg_o = 1'b1;
      req_ready_o    = 1'b0;
      done_o         = 1'b0;

      unique case (state_q)
         ST_RESET: begin
            pll_rst_o = 1'b1;
            if (tmr_q == TC_RST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            tmr_d = '0;
            if (qual)         state_d = ST_IDLE;
            else if (timeout) state_d = ST_RESET;
         end
         ST_IDLE: begin
            tmr_d = '0;
            // Not ready on a lock-loss cycle, so a request is never taken
            // and then silently dropped by the forced reset.
            req_ready_o = lk_s;
            if (req_valid_i && lk_s) begin
               sel_d   = req_sel_i;
               dir_d   = req_dir_i;
               steps_d = req_steps_i;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_q == TC_STEP) state_d = (steps_q != '0) ? ST_STEP_LO : ST_DONE;
         end
         ST_STEP_LO: begin
            phasestep_o = 1'b0;
            if (tmr_q == TC_STEP) state_d = ST_STEP_HI;
         end
         ST_STEP_HI: begin
            if (tmr_q == TC_STEP) begin
               if (steps_q != '0) steps_d = steps_q - STEPW'(1);
               state_d = (steps_q <= STEPW'(1)) ? ST_LOAD_LO : ST_STEP_LO;
            end
         end
         ST_LOAD_LO: begin
            phaseloadreg_o = 1'b0;
            if (tmr_q == TC_STEP) state_d = ST_LOAD_HI;
         end
         ST_LOAD_HI: begin
            if (tmr_q == TC_STEP) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (tmr_q == TC_SETTLE) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_RESET;
      endcase

      // Lock loss wins over everything: pulses release high in the same cycle
      // and any in-flight request is dropped without done.
      if (lockloss) begin
         state_d        = ST_RESET;
         phasestep_o    = 1'b1;
         phaseloadreg_o = 1'b1;
         req_ready_o    = 1'b0;
         done_o         = 1'b0;
      end

      if (state_d != state_q) tmr_d = '0;
   end

   assign phasesel_o = sel_q;
   assign phasedir_o = dir_q;
   assign lockloss_o = lockloss;

`ifdef PLL_PHASE_CTRL_TRACK_EN
   localparam int AW = STEPW + 4;
   localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   logic [AW-1:0] acc_q [4];
   logic [AW-1:0] acc_cur, acc_nxt;
   logic          step_done;

   // A step counts only once its high phase completes with lock still valid.
   assign step_done = (state_q == ST_STEP_HI) && (tmr_q == TC_STEP) && lk_s;
   assign acc_cur   = acc_q[sel_q];

   always_comb begin
      acc_nxt = acc_cur;
      if (dir_q && (acc_cur != ACC_MAX))       acc_nxt = acc_cur + AW'(1);
      else if (!dir_q && (acc_cur != ACC_MIN)) acc_nxt = acc_cur - AW'(1);
   end

   // Cleared by rst_n only; a PLL reset leaves the history intact.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 4; i++) acc_q[i] <= '0;
      end else if (step_done) begin
         acc_q[sel_q] <= acc_nxt;
      end
   end

   assign phase_acc_o = {acc_q[3], acc_q[2], acc_q[1], acc_q[0]};
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
`timescale 1ns/1ps
module tb_pll_phase_ctrl;
   import pll_phase_ctrl_pkg::*;

   localparam int STEPW      = 8;
   localparam int AW         = STEPW + 4;
   localparam int TB_TIMEOUT = 4096;

   logic             clk_i = 1'b0;
   logic             rst_n_i = 1'b0;
   logic             pll_locked_i = 1'b1;
   logic             pll_rst_o;
   logic [1:0]       phasesel_o;
   logic             phasedir_o;
   logic             phasestep_o;
   logic             phaseloadreg_o;
   logic             req_valid_i = 1'b0;
   logic             req_ready_o;
   logic [1:0]       req_sel_i = 2'd0;
   logic             req_dir_i = 1'b0;
   logic [STEPW-1:0] req_steps_i = '0;
   logic             done_o;
   logic             locked_o;
   logic             lockloss_o;
`ifdef PLL_PHASE_CTRL_TRACK_EN
   logic [4*AW-1:0]  phase_acc_o;
`endif

   pll_phase_ctrl #(
      .LOCK_TIMEOUT (TB_TIMEOUT),
      .STEPW        (STEPW)
   ) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .pll_locked_i   (pll_locked_i),
      .pll_rst_o      (pll_rst_o),
      .phasesel_o     (phasesel_o),
      .phasedir_o     (phasedir_o),
      .phasestep_o    (phasestep_o),
      .phaseloadreg_o (phaseloadreg_o),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_sel_i      (req_sel_i),
      .req_dir_i      (req_dir_i),
      .req_steps_i    (req_steps_i),
      .done_o         (done_o),
      .locked_o       (locked_o),
      .lockloss_o     (lockloss_o)
`ifdef PLL_PHASE_CTRL_TRACK_EN
      ,
      .phase_acc_o    (phase_acc_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_acc [4] = '{0, 0, 0, 0};

   typedef struct {
      logic [1:0]       sel;
      logic             dir;
      logic [STEPW-1:0] steps;
      int               lat;
      int               pul;
      int               lpul;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

`ifdef PLL_PHASE_CTRL_TRACK_EN
   task automatic check_acc(input string name);
      logic signed [AW-1:0] f;
      for (int i = 0; i < 4; i++) begin
         f = phase_acc_o[i*AW +: AW];
         check($sformatf("%s_acc%0d", name, i), f, exp_acc[i]);
      end
   endtask
`endif

   // Counts pll_rst-high samples, then samples with pll_rst low and no lock.
   task automatic measure_powerup(output int hi, output int lo, output logic got);
      hi = 0;
      lo = 0;
      while (pll_rst_o === 1'b1 && hi < 200) begin
         hi++;
         @(negedge clk_i);
      end
      while (pll_rst_o === 1'b0 && locked_o !== 1'b1 && lo < 6000) begin
         lo++;
         @(negedge clk_i);
      end
      got = locked_o;
   endtask

   // Latency counts from the accept cycle (0) to the done sample.
   task automatic run_req(input logic [1:0] sel, input logic dir, input logic [STEPW-1:0] steps,
                          output int lat, output int st_low, output int st_pul,
                          output int ld_low, output int ld_pul, output int hold_err);
      logic prev_st, prev_ld;
      int   w;
      lat = -1; st_low = 0; st_pul = 0; ld_low = 0; ld_pul = 0; hold_err = 0;
      req_sel_i   = sel;
      req_dir_i   = dir;
      req_steps_i = steps;
      req_valid_i = 1'b1;
      w = 0;
      while (req_ready_o !== 1'b1 && w < 3000) begin
         @(negedge clk_i);
         w++;
      end
      if (req_ready_o !== 1'b1) begin
         req_valid_i = 1'b0;
         return;
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      lat = 1;
      prev_st = 1'b1;
      prev_ld = 1'b1;
      while (done_o !== 1'b1 && lat < 3000) begin
         if (phasesel_o !== sel || phasedir_o !== dir) hold_err++;
         if (phasestep_o === 1'b0) begin
            st_low++;
            if (prev_st) st_pul++;
         end
         if (phaseloadreg_o === 1'b0) begin
            ld_low++;
            if (prev_ld) ld_pul++;
         end
         prev_st = phasestep_o;
         prev_ld = phaseloadreg_o;
         @(negedge clk_i);
         lat++;
      end
      if (phasesel_o !== sel || phasedir_o !== dir) hold_err++;
      if (done_o !== 1'b1) lat = -1;
   endtask

   initial begin
      vec_t vecs [6];
      int   hi, lo, lat, st_low, st_pul, ld_low, ld_pul, hold_err, w, d, falls, done_seen;
      logic got, prev;

      vecs[0] = '{2'b01, 1'b1, 8'd3,   101,  3,   1};
      vecs[1] = '{2'b00, 1'b0, 8'd0,   5,    0,   0};
      vecs[2] = '{2'b11, 1'b1, 8'd1,   85,   1,   1};
      vecs[3] = '{2'b10, 1'b0, 8'd2,   93,   2,   1};
      vecs[4] = '{2'b11, 1'b0, 8'd255, 2117, 255, 1};
      vecs[5] = '{2'b01, 1'b1, 8'd0,   5,    0,   0};

      // Power-up with LOCK already high.
      repeat (3) @(negedge clk_i);
      check("rst_pll_rst", pll_rst_o, 1);
      check("rst_phasesel", phasesel_o, 0);
      check("rst_phasedir", phasedir_o, 0);
      check("rst_phasestep", phasestep_o, 1);
      check("rst_phaseloadreg", phaseloadreg_o, 1);
      check("rst_req_ready", req_ready_o, 0);
      check("rst_done", done_o, 0);
      check("rst_locked", locked_o, 0);
      check("rst_lockloss", lockloss_o, 0);
`ifdef PLL_PHASE_CTRL_TRACK_EN
      check_acc("rst");
`endif
      rst_n_i = 1'b1;
      measure_powerup(hi, lo, got);
      check("pwrup_rst_cycles", hi, 16);
      check("pwrup_wait_cycles", lo, 1024);
      check("pwrup_locked", got, 1);
      check("pwrup_ready", req_ready_o, 1);

      // Table-driven requests.
      for (int i = 0; i < 6; i++) begin
         run_req(vecs[i].sel, vecs[i].dir, vecs[i].steps, lat, st_low, st_pul, ld_low, ld_pul, hold_err);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_step_pulses", i), st_pul, vecs[i].pul);
         check($sformatf("v%0d_step_low", i), st_low, 4 * vecs[i].pul);
         check($sformatf("v%0d_load_pulses", i), ld_pul, vecs[i].lpul);
         check($sformatf("v%0d_load_low", i), ld_low, 4 * vecs[i].lpul);
         check($sformatf("v%0d_sel_dir_hold", i), hold_err, 0);
         exp_acc[vecs[i].sel] += vecs[i].dir ? int'(vecs[i].steps) : -int'(vecs[i].steps);
         @(negedge clk_i);
         check($sformatf("v%0d_done_one_cycle", i), done_o, 0);
         check($sformatf("v%0d_ready_after", i), req_ready_o, 1);
`ifdef PLL_PHASE_CTRL_TRACK_EN
         check_acc($sformatf("v%0d", i));
`endif
      end

      // Lock loss during the second step of a 5-step request.
      req_sel_i = 2'b10; req_dir_i = 1'b0; req_steps_i = 8'd5; req_valid_i = 1'b1;
      w = 0;
      while (req_ready_o !== 1'b1 && w < 100) begin
         @(negedge clk_i);
         w++;
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      falls = 0;
      prev = 1'b1;
      w = 0;
      while (falls < 2 && w < 500) begin
         if (phasestep_o === 1'b0 && prev) falls++;
         prev = phasestep_o;
         if (falls < 2) begin
            @(negedge clk_i);
            w++;
         end
      end
      check("ll_second_pulse_seen", falls, 2);
      pll_locked_i = 1'b0;
      d = 0;
      done_seen = 0;
      while (lockloss_o !== 1'b1 && d < 10) begin
         @(negedge clk_i);
         d++;
         if (done_o === 1'b1) done_seen++;
      end
      check("ll_sync_delay", d, 2);
      check("ll_phasestep_released", phasestep_o, 1);
      check("ll_locked_drop", locked_o, 0);
      check("ll_pll_rst_same_cycle", pll_rst_o, 0);
      exp_acc[2] -= 1;
      @(negedge clk_i);
      check("ll_pll_rst_next", pll_rst_o, 1);
      check("ll_pulse_one_cycle", lockloss_o, 0);
      req_sel_i = 2'b10; req_dir_i = 1'b0; req_steps_i = 8'd1; req_valid_i = 1'b1;
      pll_locked_i = 1'b1;
      w = 0;
      while (req_ready_o !== 1'b1 && w < 3000) begin
         if (done_o === 1'b1) done_seen++;
         @(negedge clk_i);
         w++;
      end
      check("ll_no_done", done_seen, 0);
      check("ll_ready_after_relock", w, 1040);
      check("ll_locked_at_ready", locked_o, 1);
      run_req(2'b10, 1'b0, 8'd1, lat, st_low, st_pul, ld_low, ld_pul, hold_err);
      check("ll_retry_latency", lat, 85);
      check("ll_retry_pulses", st_pul, 1);
      exp_acc[2] -= 1;
      @(negedge clk_i);
`ifdef PLL_PHASE_CTRL_TRACK_EN
      check_acc("ll");
`endif

      // rst_n low for one cycle while phaseloadreg is low.
      req_sel_i = 2'b11; req_dir_i = 1'b1; req_steps_i = 8'd2; req_valid_i = 1'b1;
      w = 0;
      while (req_ready_o !== 1'b1 && w < 100) begin
         @(negedge clk_i);
         w++;
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      w = 0;
      while (phaseloadreg_o !== 1'b0 && w < 500) begin
         @(negedge clk_i);
         w++;
      end
      check("rm_load_low_seen", phaseloadreg_o, 0);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check("rm_phaseloadreg", phaseloadreg_o, 1);
      check("rm_pll_rst", pll_rst_o, 1);
      check("rm_locked", locked_o, 0);
      check("rm_phasesel", phasesel_o, 0);
      check("rm_phasedir", phasedir_o, 0);
      check("rm_req_ready", req_ready_o, 0);
      exp_acc = '{0, 0, 0, 0};
`ifdef PLL_PHASE_CTRL_TRACK_EN
      check_acc("rm");
`endif
      rst_n_i = 1'b1;
      measure_powerup(hi, lo, got);
      check("rm_rst_cycles", hi, 16);
      check("rm_wait_cycles", lo, 1024);
      check("rm_relocked", got, 1);

      // LOCK never asserts: PLL reset repeats after each timeout.
      pll_locked_i = 1'b0;
      rst_n_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      measure_powerup(hi, lo, got);
      check("to_rst_cycles", hi, 16);
      check("to_wait_cycles", lo, TB_TIMEOUT);
      check("to_locked", got, 0);
      measure_powerup(hi, lo, got);
      check("to_repulse_cycles", hi, 16);
      check("to_wait_cycles2", lo, TB_TIMEOUT);
      check("to_locked2", got, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
